pipe_stage_reg: RTL and testbench

//  Parametrised elastic pipeline-stage register for the miniCPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 tb/tb_pipe_stage_reg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with optional skid entry, flush and write-enable kill.
// Latency 1 cycle; with SKID=1 in_ready is registered (only S occupancy), with SKID=0 it follows out_ready.
module pipe_stage_reg #(
  parameter int                PAYLOAD_W = 133,
  parameter int                CTRL_W    = 4,
  parameter logic [CTRL_W-1:0] KILL_MASK = 4'b0011,
  parameter int                SKID      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic [CTRL_W-1:0]    in_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [1:0]           occupancy
);

  logic                 m_valid_q, m_valid_d;
  logic [PAYLOAD_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0]    m_ctrl_q, m_ctrl_d;
  logic                 s_valid_q, s_valid_d;
  logic [PAYLOAD_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0]    s_ctrl_q, s_ctrl_d;
  logic                 in_fire, out_fire;

  // rst gating keeps the producer stalled during reset in both modes
  assign in_ready  = (SKID != 0) ? (!rst && !s_valid_q)
                                 : (!rst && (!m_valid_q || out_ready));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_valid_q && out_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q & ~(KILL_MASK & {CTRL_W{~m_valid_q}});
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (SKID == 0) begin
      if (in_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end else if (out_fire) begin
        m_valid_d = 1'b0;
      end
    end else begin
      if (out_fire || !m_valid_q) begin
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          m_ctrl_d  = s_ctrl_q;
          s_valid_d = in_fire;
          if (in_fire) begin
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
          end
        end else begin
          m_valid_d = in_fire;
          if (in_fire) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end
        end
      end else if (in_fire) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
        s_ctrl_d  = in_ctrl;
      end
    end
    // Data may keep whatever was loaded; only the valid bits matter after a kill
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg; index 1 is SKID=1, index 0 is SKID=0.
module tb_pipe_stage_reg;

  localparam int PW = 133;
  localparam int CW = 4;
  localparam int VW = 140;

  logic          clk;
  logic          rst;
  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [PW-1:0] in_data   [2];
  logic [CW-1:0] in_ctrl   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [PW-1:0] out_data  [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [1:0]    occupancy [2];

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .KILL_MASK(4'b0011), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_ctrl(out_ctrl[0]), .occupancy(occupancy[0])
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .KILL_MASK(4'b0011), .SKID(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_ctrl(out_ctrl[1]), .occupancy(occupancy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input logic [PW-1:0] d, input logic [CW-1:0] c);
    in_valid[1] = v;
    in_data[1]  = d;
    in_ctrl[1]  = c;
  endtask

  logic [PW+CW-1:0] sbq0[$];
  logic [PW+CW-1:0] sbq1[$];
  logic [PW+CW-1:0] exp_e;
  logic             pend [2];
  logic [159:0]     rnd;
  logic             ifire, ofire;
  int               qsz;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
      in_data[k] = PW'(8'h55); in_ctrl[k] = 4'hF;
    end

    // Reset: producer stalled during reset, clean empty stage afterwards
    @(negedge clk);
    check_vec("rst_in_ready0", VW'(in_ready[0]), VW'(1'b0));
    check_vec("rst_in_ready1", VW'(in_ready[1]), VW'(1'b0));
    step();
    rst = 1'b0;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_vec("rst_out_valid", VW'(out_valid[k]), VW'(1'b0));
      check_vec("rst_out_data",  VW'(out_data[k]),  VW'(0));
      check_vec("rst_out_ctrl",  VW'(out_ctrl[k]),  VW'(0));
      check_vec("rst_occ",       VW'(occupancy[k]), VW'(0));
      check_vec("rst_in_ready",  VW'(in_ready[k]),  VW'(1'b1));
    end
    step();

    // Stream 1..4 with out_ready=1 on both variants
    for (int i = 1; i <= 5; i++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = (i <= 4);
        in_data[k]  = PW'(i);
        in_ctrl[k]  = 4'h3;
      end
      if (i > 1) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          check_vec("stream_valid", VW'(out_valid[k]), VW'(1'b1));
          check_vec("stream_data",  VW'(out_data[k]),  VW'(i - 1));
          check_vec("stream_occ",   VW'(occupancy[k]), VW'(1));
        end
      end
      step();
    end
    @(negedge clk);
    check_vec("stream_drain0", VW'(out_valid[0]), VW'(1'b0));
    check_vec("stream_drain1", VW'(out_valid[1]), VW'(1'b0));
    step();

    // Stall with skid: A in M, B in S, C blocked, then drain in order
    out_ready[1] = 1'b0;
    drive1(1'b1, PW'(12'hA0A), 4'h5);
    step();
    drive1(1'b1, PW'(12'hB0B), 4'h5);
    step();
    drive1(1'b1, PW'(12'hC0C), 4'h5);
    @(negedge clk);
    check_vec("stall_in_ready", VW'(in_ready[1]),  VW'(1'b0));
    check_vec("stall_occ",      VW'(occupancy[1]), VW'(2));
    check_vec("stall_head",     VW'(out_data[1]),  VW'(12'hA0A));
    step();
    out_ready[1] = 1'b1;
    @(negedge clk);
    check_vec("drain_a",         VW'(out_data[1]), VW'(12'hA0A));
    check_vec("drain_a_inready", VW'(in_ready[1]), VW'(1'b0));
    step();
    @(negedge clk);
    check_vec("drain_b",         VW'(out_data[1]), VW'(12'hB0B));
    check_vec("drain_b_inready", VW'(in_ready[1]), VW'(1'b1));
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    check_vec("drain_c",     VW'(out_data[1]),  VW'(12'hC0C));
    check_vec("drain_c_occ", VW'(occupancy[1]), VW'(1));
    step();
    @(negedge clk);
    check_vec("drain_empty", VW'(out_valid[1]), VW'(1'b0));
    step();

    // Flush with two entries held and a pending input
    out_ready[1] = 1'b0;
    drive1(1'b1, PW'(12'h111), 4'hF);
    step();
    drive1(1'b1, PW'(12'h222), 4'hF);
    step();
    drive1(1'b1, PW'(12'h333), 4'hF);
    flush[1] = 1'b1;
    @(negedge clk);
    check_vec("flush2_pre_occ", VW'(occupancy[1]), VW'(2));
    step();
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    @(negedge clk);
    check_vec("flush2_valid",   VW'(out_valid[1]), VW'(1'b0));
    check_vec("flush2_ctrl",    VW'(out_ctrl[1]),  VW'(4'b1100));
    check_vec("flush2_occ",     VW'(occupancy[1]), VW'(0));
    check_vec("flush2_inready", VW'(in_ready[1]),  VW'(1'b1));
    step();
    @(negedge clk);
    check_vec("flush2_no_ghost", VW'(out_valid[1]), VW'(1'b0));
    step();

    // Flush that coincides with an accepted input: the input is discarded
    drive1(1'b1, PW'(12'h444), 4'hF);
    step();
    drive1(1'b1, PW'(12'h555), 4'hF);
    flush[1] = 1'b1;
    @(negedge clk);
    check_vec("flush1_in_fires", VW'(in_ready[1]), VW'(1'b1));
    step();
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    @(negedge clk);
    check_vec("flush1_occ",   VW'(occupancy[1]), VW'(0));
    check_vec("flush1_valid", VW'(out_valid[1]), VW'(1'b0));
    step();
    @(negedge clk);
    check_vec("flush1_no_ghost", VW'(out_valid[1]), VW'(1'b0));
    step();

    // Reset and flush together: reset clears data too
    drive1(1'b1, PW'(12'h777), 4'hF);
    step();
    rst = 1'b1; flush[1] = 1'b1;
    @(negedge clk);
    check_vec("rstflush_inready", VW'(in_ready[1]), VW'(1'b0));
    step();
    rst = 1'b0; flush[1] = 1'b0; in_valid[1] = 1'b0;
    @(negedge clk);
    check_vec("rstflush_valid", VW'(out_valid[1]), VW'(1'b0));
    check_vec("rstflush_data",  VW'(out_data[1]),  VW'(0));
    check_vec("rstflush_ctrl",  VW'(out_ctrl[1]),  VW'(0));
    check_vec("rstflush_occ",   VW'(occupancy[1]), VW'(0));
    step();

    // Flush coinciding with an output fire: entry is still presented
    drive1(1'b1, PW'(12'hE0E), 4'hA);
    step();
    in_valid[1] = 1'b0; out_ready[1] = 1'b1; flush[1] = 1'b1;
    @(negedge clk);
    check_vec("flushfire_valid", VW'(out_valid[1]), VW'(1'b1));
    check_vec("flushfire_data",  VW'(out_data[1]),  VW'(12'hE0E));
    step();
    flush[1] = 1'b0;
    @(negedge clk);
    check_vec("flushfire_occ",   VW'(occupancy[1]), VW'(0));
    check_vec("flushfire_empty", VW'(out_valid[1]), VW'(1'b0));
    step();

    // Random traffic on both variants against a queue model
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; in_valid[k] = 1'b0; flush[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k]) begin
          rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
          in_valid[k] = ($urandom_range(0, 9) < 7);
          in_data[k]  = rnd[PW-1:0];
          in_ctrl[k]  = CW'($urandom_range(0, 15));
        end
        out_ready[k] = ($urandom_range(0, 9) < 6);
        flush[k]     = ($urandom_range(0, 99) < 3);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ifire = in_valid[k] && in_ready[k];
        ofire = out_valid[k] && out_ready[k];
        qsz = (k == 0) ? sbq0.size() : sbq1.size();
        check_vec("rand_occ", VW'(occupancy[k]), VW'(qsz));
        if (!out_valid[k])
          check_vec("rand_kill", VW'(out_ctrl[k] & 4'b0011), VW'(0));
        if (ofire) begin
          if (qsz == 0) begin
            check_vec("rand_spurious", VW'(out_valid[k]), VW'(1'b0));
          end else begin
            if (k == 0) exp_e = sbq0.pop_front();
            else        exp_e = sbq1.pop_front();
            check_vec("rand_entry", VW'({out_ctrl[k], out_data[k]}), VW'(exp_e));
          end
        end
        if (flush[k]) begin
          if (k == 0) sbq0.delete();
          else        sbq1.delete();
        end else if (ifire) begin
          if (k == 0) sbq0.push_back({in_ctrl[k], in_data[k]});
          else        sbq1.push_back({in_ctrl[k], in_data[k]});
        end
        pend[k] = in_valid[k] && !ifire;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
